aemb_idiv: RTL

//  Iterative 32-bit integer divider; the inverse-operation companion to the 2-stage multiplier
//  in the AEMB execute path.

---
 rtl/aemb_idiv_pkg.sv | 20 ++
 rtl/aemb_idiv_step.sv | 27 ++
 rtl/aemb_idiv.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/aemb_idiv_pkg.sv
// Shared constants for the AEMB iterative divider: state encoding,
// datapath/counter widths and a conditional negate helper.
package aemb_idiv_pkg;

   localparam int DW = 32;
   localparam int CW = 5;

   localparam logic [CW-1:0] CNT_INIT = CW'(DW - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   // two's-complement negate when n is set, pass-through otherwise
   function automatic logic [DW-1:0] neg_if(input logic [DW-1:0] v, input logic n);
      return n ? (~v + {{(DW-1){1'b0}}, 1'b1}) : v;
   endfunction

endpackage

// File: rtl/aemb_idiv_step.sv
// One radix-2 restoring division step: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, record the quotient bit.
module aemb_idiv_step
   import aemb_idiv_pkg::*;
(
   input  logic [DW-1:0] r_i,
   input  logic [DW-1:0] q_i,
   input  logic [DW-1:0] d_i,
   output logic [DW-1:0] r_o,
   output logic [DW-1:0] q_o
);

   logic [DW:0]   sh;
   logic [DW-1:0] diff;
   logic          ge;

   // compare in DW+1 bits; when it fits, the difference is below the divisor
   // so the low DW bits of the subtraction are exact
   always_comb begin
      sh   = {r_i, q_i[DW-1]};
      ge   = (sh >= {1'b0, d_i});
      diff = sh[DW-1:0] - d_i;
      r_o  = ge ? diff : sh[DW-1:0];
      q_o  = {q_i[DW-2:0], ge};
   end

endmodule

// File: rtl/aemb_idiv.sv
// AEMB iterative 32-bit divider (rD = rB / rA), signed or unsigned,
// one quotient bit per enabled clock. Define AEMB_IDIV_REM_EN to expose
// the remainder on m_rem. DIV=0 ties all outputs low.
module aemb_idiv
   import aemb_idiv_pkg::*;
#(
   parameter int DIV = 1
)(
   input  logic          gclk,
   input  logic          grst,
   input  logic          gena,
   input  logic          x_start,
   input  logic          x_sgn,
   input  logic [DW-1:0] x_opa,
   input  logic [DW-1:0] x_opb,
   output logic [DW-1:0] m_div,
   output logic          m_busy,
   output logic          m_done,
   output logic          m_dz
`ifdef AEMB_IDIV_REM_EN
  ,output logic [DW-1:0] m_rem
`endif
);

   generate
      if (DIV != 0) begin : g_div
         logic [1:0]    state_q, state_d;
         logic [CW-1:0] cnt_q, cnt_d;
         logic [DW-1:0] r_q, r_d, q_q, q_d, d_q, d_d;
         logic          qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
         logic [DW-1:0] div_q, div_d;
         logic          done_q, done_d, mdz_q, mdz_d;
`ifdef AEMB_IDIV_REM_EN
         logic [DW-1:0] rem_q, rem_d;
`endif
         logic [DW-1:0] step_r, step_q;

         aemb_idiv_step u_step (
            .r_i (r_q),
            .q_i (q_q),
            .d_i (d_q),
            .r_o (step_r),
            .q_o (step_q)
         );

         // FSM and datapath next-state
         always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            r_d     = r_q;
            q_d     = q_q;
            d_d     = d_q;
            qneg_d  = qneg_q;
            rneg_d  = rneg_q;
            dz_d    = dz_q;
            div_d   = div_q;
            mdz_d   = mdz_q;
            done_d  = 1'b0;
`ifdef AEMB_IDIV_REM_EN
            rem_d   = rem_q;
`endif
            case (state_q)
               S_IDLE: begin
                  if (x_start) begin
                     d_d    = neg_if(x_opa, x_sgn & x_opa[DW-1]);
                     qneg_d = x_sgn & (x_opa[DW-1] ^ x_opb[DW-1]);
                     rneg_d = x_sgn & x_opb[DW-1];
                     cnt_d  = CNT_INIT;
                     if (x_opa == '0) begin
                        // divide by zero: quotient 0, remainder is the raw dividend
                        state_d = S_DONE;
                        dz_d    = 1'b1;
                        q_d     = '0;
                        r_d     = x_opb;
                     end else begin
                        state_d = S_CALC;
                        dz_d    = 1'b0;
                        q_d     = neg_if(x_opb, x_sgn & x_opb[DW-1]);
                        r_d     = '0;
                     end
                  end
               end
               S_CALC: begin
                  r_d   = step_r;
                  q_d   = step_q;
                  cnt_d = cnt_q - 1'b1;
                  if (cnt_q == '0) state_d = S_FIX;
               end
               S_FIX: begin
                  q_d     = neg_if(q_q, qneg_q);
                  r_d     = neg_if(r_q, rneg_q);
                  state_d = S_DONE;
               end
               S_DONE: begin
                  done_d  = 1'b1;
                  div_d   = q_q;
                  mdz_d   = dz_q;
`ifdef AEMB_IDIV_REM_EN
                  rem_d   = r_q;
`endif
                  state_d = S_IDLE;
               end
               default: state_d = S_IDLE;
            endcase
         end

         // state update; gena low freezes everything including the done level
         always_ff @(posedge gclk or negedge grst) begin
            if (!grst) begin
               state_q <= S_IDLE;
               cnt_q   <= '0;
               r_q     <= '0;
               q_q     <= '0;
               d_q     <= '0;
               qneg_q  <= 1'b0;
               rneg_q  <= 1'b0;
               dz_q    <= 1'b0;
               div_q   <= '0;
               mdz_q   <= 1'b0;
               done_q  <= 1'b0;
`ifdef AEMB_IDIV_REM_EN
               rem_q   <= '0;
`endif
            end else if (gena) begin
               state_q <= state_d;
               cnt_q   <= cnt_d;
               r_q     <= r_d;
               q_q     <= q_d;
               d_q     <= d_d;
               qneg_q  <= qneg_d;
               rneg_q  <= rneg_d;
               dz_q    <= dz_d;
               div_q   <= div_d;
               mdz_q   <= mdz_d;
               done_q  <= done_d;
`ifdef AEMB_IDIV_REM_EN
               rem_q   <= rem_d;
`endif
            end
         end

         assign m_div  = div_q;
         assign m_dz   = mdz_q;
         assign m_done = done_q;
         // busy covers the whole operation through the done cycle
         assign m_busy = (state_q != S_IDLE) | done_q;
`ifdef AEMB_IDIV_REM_EN
         assign m_rem  = rem_q;
`endif
      end else begin : g_nodiv
         logic unused_in;
         assign unused_in = ^{gclk, grst, gena, x_start, x_sgn, x_opa, x_opb};
         assign m_div  = '0;
         assign m_busy = 1'b0;
         assign m_done = 1'b0;
         assign m_dz   = 1'b0;
`ifdef AEMB_IDIV_REM_EN
         assign m_rem  = '0;
`endif
      end
   endgenerate

endmodule
